// File: rtl/int_sched_pkg.sv
// Shared types for the intersection issue/collect path: ray and triangle IDs,
// the int_math pipe-1 bundle, and the result entry handed downstream.
package int_sched_pkg;

  typedef logic [15:0] rayID_t;
  typedef logic [15:0] triID_t;

  typedef struct packed {
    rayID_t rayID;
  } ray_t;

  typedef struct packed {
    triID_t triID;
  } intersection_t;

  typedef struct packed {
    ray_t        ray;
    logic [31:0] t_max;
    triID_t      tri0_ID;
    triID_t      tri1_ID;
    logic        tri1_valid;
  } int_pipe1_t;

  typedef struct packed {
    rayID_t rayID;
    logic   hit;
    triID_t triID;
  } int_result_t;

  localparam int INT_LAT_EM   = 28;
  localparam int INT_LAT_FULL = 47;

  // A miss never carries a triangle, so triID is cleared whenever hit is low.
  function automatic int_result_t make_result(rayID_t id, logic hit, triID_t tri_id);
    int_result_t r;
    r.rayID = id;
    r.hit   = hit;
    r.triID = hit ? tri_id : 16'h0000;
    return r;
  endfunction

endpackage

// File: rtl/int_result_fifo.sv
// Result FIFO with two ordered write ports (port 0 lands first) and one read port.
// The head reads as zero while empty so res_out is clean out of reset.
module int_result_fifo
  import int_sched_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr0_en,
  input  int_result_t            wr0_data,
  input  logic                   wr1_en,
  input  int_result_t            wr1_data,
  input  logic                   rd_en,
  output int_result_t            rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  int_result_t   mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [AW-1:0] wr1_addr_s;
  logic [CW-1:0] cnt_r;

  assign wr1_addr_s = wptr_r + AW'(wr0_en);

  // Entry storage; port 1 follows port 0 when both write in one cycle.
  always_ff @(posedge clk) begin
    if (wr0_en) mem_r[wptr_r] <= wr0_data;
    if (wr1_en) mem_r[wr1_addr_s] <= wr1_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      wptr_r <= wptr_r + AW'(wr0_en) + AW'(wr1_en);
      rptr_r <= rptr_r + AW'(rd_en);
      cnt_r  <= cnt_r + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
    end
  end

  assign empty   = (cnt_r == '0);
  assign rd_data = empty ? '0 : mem_r[rptr_r];
  assign count   = cnt_r;

endmodule

// File: rtl/int_sched.sv
// Credit-based issue into int_math plus collection of its early-miss and
// full-result streams into a backpressured result FIFO.
module int_sched
  import int_sched_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ray_valid,
  input  int_pipe1_t    ray_in,
  output logic          ray_stall,
  output logic          issue_valid,
  output int_pipe1_t    issue_pipe,
  input  logic          em_miss,
  input  ray_t          em_ray,
  input  logic          fr_valid,
  input  logic          fr_hit,
  input  ray_t          fr_ray,
  input  intersection_t fr_isect,
  output logic          we,
  input  logic          full,
  output int_result_t   res_out,
  output logic          idle,
  output logic          err
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] cnt_s;
  logic [CW-1:0] avail_s;
  logic [CW-1:0] free_s;
  logic [CW-1:0] infl_r;
  logic [CW-1:0] infl_next_s;
  logic          accept_s;
  logic          em_ok_s;
  logic          fr_ok_s;
  logic          em_wr_s;
  logic          fr_wr_s;
  logic          err_evt_s;
  logic          empty_s;
  logic          we_s;
  logic          issue_valid_r;
  int_pipe1_t    issue_pipe_r;
  logic          err_r;
  int_result_t   em_res_s;
  int_result_t   fr_res_s;

  // Every ray in flight owns a FIFO slot, so credit is what neither holds.
  assign avail_s   = DEPTH_C - cnt_s - infl_r;
  assign ray_stall = (avail_s == '0);
  assign accept_s  = ray_valid & ~ray_stall;
  assign we_s      = ~empty_s & ~full;

  // Returns beyond what is in flight are bogus; em has priority for the last credit.
  assign em_ok_s = em_miss & (infl_r != '0);
  assign fr_ok_s = fr_valid & (infl_r > CW'(em_ok_s));
  assign free_s  = DEPTH_C - cnt_s + CW'(we_s);
  assign em_wr_s = em_ok_s & (free_s != '0);
  assign fr_wr_s = fr_ok_s & (free_s > CW'(em_wr_s));

  assign err_evt_s   = (em_miss & ~em_wr_s) | (fr_valid & ~fr_wr_s);
  assign infl_next_s = infl_r + CW'(accept_s) - CW'(em_ok_s) - CW'(fr_ok_s);

  assign em_res_s = make_result(em_ray.rayID, 1'b0, 16'h0000);
  assign fr_res_s = make_result(fr_ray.rayID, fr_hit, fr_isect.triID);

  int_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (em_wr_s),
    .wr0_data (em_res_s),
    .wr1_en   (fr_wr_s),
    .wr1_data (fr_res_s),
    .rd_en    (we_s),
    .rd_data  (res_out),
    .empty    (empty_s),
    .count    (cnt_s)
  );

  // Issue register, in-flight credit counter and sticky protocol error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid_r <= 1'b0;
      issue_pipe_r  <= '0;
      infl_r        <= '0;
      err_r         <= 1'b0;
    end else begin
      issue_valid_r <= accept_s;
      if (accept_s) begin
        issue_pipe_r <= ray_in;
      end
      infl_r <= infl_next_s;
      err_r  <= err_r | err_evt_s;
    end
  end

  assign issue_valid = issue_valid_r;
  assign issue_pipe  = issue_pipe_r;
  assign we          = we_s;
  assign err         = err_r;
  assign idle        = (infl_r == '0) & (cnt_s == '0) & ~issue_valid_r;

endmodule

// File: tb/tb_int_sched.sv
// Randomized scoreboard bench for int_sched: the bench plays int_math from
// its own record of accepted rays and predicts credits and results by counting.
module tb_int_sched;
  import int_sched_pkg::*;

  localparam int DEPTH = 64;

  typedef struct packed {
    rayID_t id;
    logic   hit;
    triID_t tri_id;
  } fr_ev_t;

  logic          clk;
  logic          rst;
  logic          ray_valid;
  int_pipe1_t    ray_in;
  logic          ray_stall;
  logic          issue_valid;
  int_pipe1_t    issue_pipe;
  logic          em_miss;
  ray_t          em_ray;
  logic          fr_valid;
  logic          fr_hit;
  ray_t          fr_ray;
  intersection_t fr_isect;
  logic          we;
  logic          full;
  int_result_t   res_out;
  logic          idle;
  logic          err;

  int_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ray_valid(ray_valid), .ray_in(ray_in), .ray_stall(ray_stall),
    .issue_valid(issue_valid), .issue_pipe(issue_pipe), .em_miss(em_miss), .em_ray(em_ray),
    .fr_valid(fr_valid), .fr_hit(fr_hit), .fr_ray(fr_ray), .fr_isect(fr_isect),
    .we(we), .full(full), .res_out(res_out), .idle(idle), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  int_result_t exp_res_q[$];
  int_pipe1_t  exp_iss_q[$];
  rayID_t      em_at[int];
  fr_ev_t      fr_at[int];

  int  m_cnt, m_infl, cyc, accepts, next_id;
  bit  m_err, m_issue, err_pend, drv_em_ok, drv_fr_ok;
  int  valid_mode, full_mode, lat_mode;
  bit  inj_fr, dir_hit;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // One clock: advance the count model on the edge, drive the next inputs, check mid-cycle.
  task automatic step();
    bit     acc;
    int     pop;
    int     ret;
    bit     use_em;
    fr_ev_t ev;
    @(posedge clk);
    acc     = ray_valid && (DEPTH - m_cnt - m_infl > 0);
    pop     = (m_cnt > 0 && !full) ? 1 : 0;
    ret     = int'(drv_em_ok) + int'(drv_fr_ok);
    m_cnt   = m_cnt - pop + ret;
    m_infl  = m_infl + (acc ? 1 : 0) - ret;
    m_issue = acc;
    m_err   = m_err | err_pend;
    err_pend = 1'b0;
    cyc++;
    if (acc) begin
      exp_iss_q.push_back(ray_in);
      accepts++;
      use_em = (lat_mode == 1) || (lat_mode == 0 && $urandom_range(1) == 0);
      if (use_em) begin
        em_at[cyc + INT_LAT_EM] = ray_in.ray.rayID;
      end else begin
        ev.id     = ray_in.ray.rayID;
        ev.hit    = dir_hit ? 1'b1 : 1'($urandom_range(1));
        ev.tri_id = dir_hit ? 16'd2 : 16'($urandom);
        fr_at[cyc + INT_LAT_FULL] = ev;
      end
      next_id++;
    end
    #1;
    ray_valid = (valid_mode == 1) || (valid_mode == 2 && $urandom_range(1) == 1);
    ray_in.ray.rayID  = rayID_t'(next_id);
    ray_in.t_max      = $urandom;
    ray_in.tri0_ID    = 16'($urandom);
    ray_in.tri1_ID    = 16'($urandom);
    ray_in.tri1_valid = 1'($urandom_range(1));
    full = (full_mode == 1) || (full_mode == 2 && $urandom_range(3) == 0);
    em_miss = em_at.exists(cyc);
    em_ray.rayID = em_miss ? em_at[cyc] : 16'($urandom);
    if (fr_at.exists(cyc)) begin
      ev = fr_at[cyc];
      fr_valid = 1'b1;
      fr_ray.rayID = ev.id;
      fr_hit = ev.hit;
      fr_isect.triID = ev.tri_id;
    end else begin
      fr_valid = inj_fr;
      fr_ray.rayID = 16'($urandom);
      fr_hit = 1'($urandom_range(1));
      fr_isect.triID = 16'($urandom);
    end
    em_at.delete(cyc);
    fr_at.delete(cyc);
    drv_em_ok = em_miss && m_infl > 0;
    drv_fr_ok = fr_valid && m_infl > (drv_em_ok ? 1 : 0);
    if ((em_miss && !drv_em_ok) || (fr_valid && !drv_fr_ok)) err_pend = 1'b1;
    if (drv_em_ok) exp_res_q.push_back(make_result(em_ray.rayID, 1'b0, 16'd0));
    if (drv_fr_ok) exp_res_q.push_back(make_result(fr_ray.rayID, fr_hit, fr_isect.triID));
    @(negedge clk);
    check("ray_stall", ray_stall, (DEPTH - m_cnt - m_infl) == 0);
    check("we", we, (m_cnt > 0) && !full);
    check("idle", idle, m_infl == 0 && m_cnt == 0 && !m_issue);
    check("err", err, m_err);
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (!(m_infl == 0 && m_cnt == 0 && !m_issue && !ray_valid && exp_res_q.size() == 0)
           && n < budget) begin
      step();
      n++;
    end
    check("drain_in_budget", n < budget, 1'b1);
  endtask

  // Result monitor: every presented entry must be the oldest expected one.
  always @(negedge clk) begin
    int_result_t e;
    if (rst && we === 1'b1) begin
      if (exp_res_q.size() == 0) begin
        check("res_unexpected", res_out, 128'd0);
        check("res_spurious_we", we, 1'b0);
      end else begin
        e = exp_res_q.pop_front();
        check("res_out", res_out, e);
      end
    end
  end

  // Issue monitor: int_math must see exactly the accepted rays, in order.
  always @(negedge clk) begin
    int_pipe1_t e;
    if (rst && issue_valid === 1'b1) begin
      if (exp_iss_q.size() == 0) begin
        check("issue_spurious", issue_valid, 1'b0);
      end else begin
        e = exp_iss_q.pop_front();
        check("issue_pipe", issue_pipe, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ray_valid = 1'b0; ray_in = '0; em_miss = 1'b0; em_ray = '0;
    fr_valid = 1'b0; fr_hit = 1'b0; fr_ray = '0; fr_isect = '0; full = 1'b0;
    m_cnt = 0; m_infl = 0; cyc = 0; accepts = 0; next_id = 1;
    m_err = 1'b0; m_issue = 1'b0; err_pend = 1'b0; drv_em_ok = 1'b0; drv_fr_ok = 1'b0;
    valid_mode = 0; full_mode = 0; lat_mode = 0; inj_fr = 1'b0; dir_hit = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("rst_we", we, 1'b0);
    check("rst_issue_valid", issue_valid, 1'b0);
    check("rst_issue_pipe", issue_pipe, 128'd0);
    check("rst_res_out", res_out, 128'd0);
    check("rst_ray_stall", ray_stall, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_err", err, 1'b0);
    #9 rst = 1'b1;

    // Single full-result hit with triID 2
    valid_mode = 1; lat_mode = 2; dir_hit = 1'b1;
    step();
    valid_mode = 0;
    drain(200);
    check("single_accepts", accepts, 1);
    dir_hit = 1'b0;

    // em (rayID 7) and fr (rayID 3) returning in the same cycle
    next_id = 3; valid_mode = 1; lat_mode = 2;
    step();
    valid_mode = 0;
    repeat (18) step();
    next_id = 7; valid_mode = 1; lat_mode = 1;
    step();
    valid_mode = 0;
    drain(200);

    // Backpressure: full held, continuous offer
    accepts = 0; next_id = 100; lat_mode = 0; full_mode = 1; valid_mode = 1;
    repeat (DEPTH + 60) step();
    check("bp_accepts", accepts, DEPTH);
    full_mode = 0;
    repeat (4) step();
    valid_mode = 0;
    drain(300);

    // Streaming: back-to-back rays, random latency mix, no backpressure
    accepts = 0; next_id = 1000; valid_mode = 1;
    repeat (200) step();
    valid_mode = 0;
    drain(200);
    check("stream_accepts", accepts, 200);
    check("stream_no_err", err, 1'b0);

    // Random offer and random backpressure
    next_id = 2000; valid_mode = 2; full_mode = 2;
    repeat (300) step();
    valid_mode = 0;
    drain(600);
    full_mode = 0;

    // Protocol error: full result with nothing in flight
    inj_fr = 1'b1;
    step();
    inj_fr = 1'b0;
    repeat (3) step();
    check("err_sticky", err, 1'b1);
    check("err_no_write", we, 1'b0);

    // Asynchronous reset with rays in flight and entries queued
    next_id = 3000; valid_mode = 1; full_mode = 1; lat_mode = 0;
    repeat (55) step();
    check("pre_rst_busy", idle, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("arst_we", we, 1'b0);
    check("arst_issue_valid", issue_valid, 1'b0);
    check("arst_idle", idle, 1'b1);
    check("arst_err", err, 1'b0);
    check("arst_ray_stall", ray_stall, 1'b0);
    valid_mode = 0; full_mode = 0;
    ray_valid = 1'b0; em_miss = 1'b0; fr_valid = 1'b0; full = 1'b0;
    exp_res_q.delete(); exp_iss_q.delete(); em_at.delete(); fr_at.delete();
    m_cnt = 0; m_infl = 0; m_err = 1'b0; m_issue = 1'b0; err_pend = 1'b0;
    drv_em_ok = 1'b0; drv_fr_ok = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;

    // Traffic after reset
    next_id = 4000; valid_mode = 2; full_mode = 2;
    repeat (80) step();
    valid_mode = 0;
    drain(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
